// File: rtl/aes_iter_core.sv
// Iterative AES-128/256 encryptor: one round per clock, round keys expanded on the fly.
// Define AES_CTR_MODE_EN to add counter mode (ctr_load / ctr_init ports).
module aes_iter_core #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef AES_CTR_MODE_EN
  input  logic                ctr_load,
  input  logic [127:0]        ctr_init,
`endif
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        data_in,
  input  logic [KEY_BITS-1:0] key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        data_out,
  output logic                busy
);

  if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key
    $error("aes_iter_core: KEY_BITS must be 128 or 256");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [3:0] NR = (KEY_BITS == 256) ? 4'd14 : 4'd10;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the top byte, so index from the MSB end.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    a0 = a[31:24];
    a1 = a[23:16];
    a2 = a[15:8];
    a3 = a[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  state_e              fsm_q;
  logic [127:0]        state_q, data_out_q;
  logic [KEY_BITS-1:0] key_q, key_d;
  logic [3:0]          round_q;
  logic                in_ready_q, out_valid_q, busy_q;

  logic [127:0] sb, sr, mc, rk, state_d;
  logic [127:0] blk_in, pad;
  logic         last_round;

  assign last_round = (round_q == NR);

  // Byte i of the state is bits [127-8i -: 8]; column c holds bytes 4c..4c+3.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sb[127-8*(4*c+r) -: 8] = sbox(state_q[127-8*(4*c+r) -: 8]);
      assign sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
    end
    assign mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
  end

  assign state_d = (last_round ? sr : mc) ^ rk;

  if (KEY_BITS == 256) begin : g_ks256
    // Window holds {K(r-1), K(r)} during round r; K(r+1) is built for the next round.
    logic [3:0]   nxt_idx;
    logic [31:0]  t;
    logic [127:0] nk;
    assign nxt_idx = round_q + 4'd1;
    assign t = nxt_idx[0] ? sub_word(key_q[31:0])
                          : (sub_word(rot_word(key_q[31:0])) ^ {rcon({1'b0, nxt_idx[3:1]}), 24'h0});
    assign nk[127:96] = key_q[255:224] ^ t;
    assign nk[95:64]  = key_q[223:192] ^ nk[127:96];
    assign nk[63:32]  = key_q[191:160] ^ nk[95:64];
    assign nk[31:0]   = key_q[159:128] ^ nk[63:32];
    assign rk    = key_q[127:0];
    assign key_d = {key_q[127:0], nk};
  end else begin : g_ks128
    logic [31:0] t;
    assign t = sub_word(rot_word(key_q[31:0])) ^ {rcon(round_q), 24'h0};
    assign rk[127:96] = key_q[127:96] ^ t;
    assign rk[95:64]  = key_q[95:64] ^ rk[127:96];
    assign rk[63:32]  = key_q[63:32] ^ rk[95:64];
    assign rk[31:0]   = key_q[31:0] ^ rk[63:32];
    assign key_d = rk;
  end

`ifdef AES_CTR_MODE_EN
  logic [127:0] ctr_q, din_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr_q <= '0;
      din_q <= '0;
    end else begin
      if (fsm_q == IDLE && ctr_load) begin
        ctr_q <= ctr_init;
      end else if (fsm_q == DONE && out_ready) begin
        ctr_q <= ctr_q + 128'd1;
      end
      if (fsm_q == IDLE && in_valid) begin
        din_q <= data_in;
      end
    end
  end

  assign blk_in = ctr_q;
  assign pad    = din_q;
`else
  assign blk_in = data_in;
  assign pad    = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      key_q       <= '0;
      round_q     <= '0;
      data_out_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            state_q    <= blk_in ^ key[KEY_BITS-1 -: 128];
            key_q      <= key;
            round_q    <= 4'd1;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            fsm_q      <= RUN;
          end
        end
        RUN: begin
          state_q <= state_d;
          key_q   <= key_d;
          if (last_round) begin
            data_out_q  <= state_d ^ pad;
            out_valid_q <= 1'b1;
            fsm_q       <= DONE;
          end else begin
            round_q <= round_q + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            round_q     <= '0;
            fsm_q       <= IDLE;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_aes_iter_core.sv
// Directed bench for aes_iter_core: FIPS-197 vectors for AES-128/256, backpressure,
// input stability, mid-run reset, and counter mode when AES_CTR_MODE_EN is defined.
module tb_aes_iter_core;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [127:0] a_data_in, a_key, a_data_out;
  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [127:0] b_data_in, b_data_out;
  logic [255:0] b_key;
  logic         a_ctr_load, b_ctr_load;
  logic [127:0] a_ctr_init, b_ctr_init;

  int n_asrt = 0;
  int n_fail = 0;
  int lat;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] E1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] K2 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] E2 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] K3 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P3 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] E3 = 128'h3925841d02dc09fbdc118597196a0b32;

  aes_iter_core #(.KEY_BITS(128)) u128 (
    .clk(clk), .rst_n(rst_n),
`ifdef AES_CTR_MODE_EN
    .ctr_load(a_ctr_load), .ctr_init(a_ctr_init),
`endif
    .in_valid(a_in_valid), .in_ready(a_in_ready), .data_in(a_data_in), .key(a_key),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .data_out(a_data_out), .busy(a_busy)
  );

  aes_iter_core #(.KEY_BITS(256)) u256 (
    .clk(clk), .rst_n(rst_n),
`ifdef AES_CTR_MODE_EN
    .ctr_load(b_ctr_load), .ctr_init(b_ctr_init),
`endif
    .in_valid(b_in_valid), .in_ready(b_in_ready), .data_in(b_data_in), .key(b_key),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .data_out(b_data_out), .busy(b_busy)
  );

  task automatic check128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Presents one plaintext to the 128-bit core; in counter mode the plaintext is
  // loaded as the counter and zero data is supplied so the output is plain AES.
  task automatic start_a(input logic [127:0] k, input logic [127:0] pt);
`ifdef AES_CTR_MODE_EN
    a_ctr_load = 1'b1;
    a_ctr_init = pt;
    @(posedge clk); #1;
    a_ctr_load = 1'b0;
    a_data_in  = '0;
`else
    a_data_in  = pt;
`endif
    a_key      = k;
    a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic wait_a(output int cycles);
    cycles = 0;
    while (!a_out_valid && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_out_ready = 1'b1; a_data_in = '0; a_key = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b1; b_data_in = '0; b_key = '0;
    a_ctr_load = 1'b0; a_ctr_init = '0; b_ctr_load = 1'b0; b_ctr_init = '0;
    repeat (2) @(posedge clk);
    #1;
    check_bit("rst_in_ready", a_in_ready, 1'b1);
    check_bit("rst_out_valid", a_out_valid, 1'b0);
    check_bit("rst_busy", a_busy, 1'b0);
    check128("rst_data_out", a_data_out, '0);
    check_bit("rst256_in_ready", b_in_ready, 1'b1);
    rst_n = 1'b1;

    // AES-128 FIPS-197 C.1
    start_a(K1, P1);
    check_bit("t1_busy", a_busy, 1'b1);
    check_bit("t1_in_ready", a_in_ready, 1'b0);
    wait_a(lat);
    check_int("t1_latency", lat, 10);
    check128("t1_data", a_data_out, E1);
    @(posedge clk); #1;
    check_bit("t1_ret_out_valid", a_out_valid, 1'b0);
    check_bit("t1_ret_in_ready", a_in_ready, 1'b1);
    check_bit("t1_ret_busy", a_busy, 1'b0);

    // AES-256 FIPS-197 C.3
`ifdef AES_CTR_MODE_EN
    b_ctr_load = 1'b1;
    b_ctr_init = P1;
    @(posedge clk); #1;
    b_ctr_load = 1'b0;
    b_data_in  = '0;
`else
    b_data_in  = P1;
`endif
    b_key = K2;
    b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    check_bit("t2_busy", b_busy, 1'b1);
    lat = 0;
    while (!b_out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check_int("t2_latency", lat, 14);
    check128("t2_data", b_data_out, E2);
    @(posedge clk); #1;
    check_bit("t2_ret_out_valid", b_out_valid, 1'b0);
    check_bit("t2_ret_in_ready", b_in_ready, 1'b1);

    // Backpressure with stray in_valid during DONE
    a_out_ready = 1'b0;
    start_a(K3, P3);
    wait_a(lat);
    check_int("t3_latency", lat, 10);
    check128("t3_data", a_data_out, E3);
    for (int i = 0; i < 20; i++) begin
      a_in_valid = 1'b1;
      a_data_in  = {$urandom, $urandom, $urandom, $urandom};
      a_key      = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      check128("t3_hold_data", a_data_out, E3);
      check_bit("t3_hold_valid", a_out_valid, 1'b1);
      check_bit("t3_hold_in_ready", a_in_ready, 1'b0);
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    check_bit("t3_ret_out_valid", a_out_valid, 1'b0);
    check_bit("t3_ret_in_ready", a_in_ready, 1'b1);
    @(posedge clk); #1;
    check_bit("t3_no_stray_accept", a_busy, 1'b0);

    // Inputs scrambled every cycle while the block is in flight
    start_a(K1, P1);
    lat = 0;
    while (!a_out_valid && lat < 40) begin
      a_in_valid = 1'($urandom);
      a_data_in  = {$urandom, $urandom, $urandom, $urandom};
      a_key      = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      lat++;
    end
    a_in_valid = 1'b0;
    check_int("t4_latency", lat, 10);
    check128("t4_data", a_data_out, E1);
    @(posedge clk); #1;
    check_bit("t4_ret_out_valid", a_out_valid, 1'b0);

    // Asynchronous reset during round 5
    start_a(K3, P3);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_bit("t5_rst_out_valid", a_out_valid, 1'b0);
    check128("t5_rst_data_out", a_data_out, '0);
    check_bit("t5_rst_busy", a_busy, 1'b0);
    check_bit("t5_rst_in_ready", a_in_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_bit("t5_idle_after_rst", a_busy, 1'b0);
    start_a(K3, P3);
    wait_a(lat);
    check_int("t5_latency", lat, 10);
    check128("t5_data", a_data_out, E3);
    @(posedge clk); #1;
    check_bit("t5_ret_in_ready", a_in_ready, 1'b1);

`ifdef AES_CTR_MODE_EN
    // Counter mode: counter all-ones, then wrap to zero (key all zeros)
    begin
      logic [127:0] d1, d2;
      d1 = 128'h0123456789abcdeffedcba9876543210;
      d2 = 128'hdeadbeefcafef00d0badc0de12345678;
      a_ctr_load = 1'b1;
      a_ctr_init = '1;
      @(posedge clk); #1;
      a_ctr_load = 1'b0;
      a_key = '0;
      a_data_in = d1;
      a_in_valid = 1'b1;
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      a_data_in = '1;
      wait_a(lat);
      check_int("t6_latency", lat, 10);
      check128("t6_ctr_ones", a_data_out, 128'h3f5b8cc9ea855a0afa7347d23e8d664e ^ d1);
      @(posedge clk); #1;
      a_data_in = d2;
      a_in_valid = 1'b1;
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      wait_a(lat);
      check128("t6_ctr_wrap", a_data_out, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e ^ d2);
      @(posedge clk); #1;
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
